// File: rtl/fetch_unit.sv
// Instruction fetch stage: generates the PC, issues single-cycle imem reads and
// buffers the returned words in a small prefetch queue for the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          not_empty;

    // The outstanding read reserves a slot, so the queue can never overflow.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue     = reset & ~redirect & (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_q & ~redirect;
    assign not_empty = (count_q != '0);
    assign pop       = instr_valid & instr_ready;

    assign imem_rd_en  = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = not_empty & ~redirect;
    assign instr       = not_empty ? data_mem_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
